// File: rtl/execute_muldiv.sv
// Multi-cycle RISC-V M-extension execute unit: shift-add multiply and
// restoring divide on operand magnitudes, one bit per cycle, with
// valid/ready handshakes on both sides and a synchronous flush.
//
// state | meaning
// IDLE  | ready_o high, waiting for an operation
// BUSY  | iterating one multiplier / quotient bit per cycle
// FIX   | sign correction and result select into the output registers
// DONE  | valid_o high, outputs held until ready_i
module execute_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      addr_rd_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      addr_rd_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

    state_t state_q, state_d;

    logic [2:0]        op_q, op_d;
    logic              s1_q, s1_d, s2_q, s2_d;
    logic              div0_q, div0_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // multiply: {partial product high, remaining multiplier bits}
    // divide:   low half shifts dividend bits out and quotient bits in
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   pc_q, pc_d, pc4_q, pc4_d;
    logic [XLEN-1:0]   result_q, result_d, pc_out_q, pc_out_d, pc4_out_q, pc4_out_d;
    logic [4:0]        rd_out_q, rd_out_d;

    logic              sgn1_op, sgn2_op, s1_in, s2_in;
    logic [XLEN-1:0]   op1_mag, op2_mag;
    logic [XLEN:0]     mul_sum, mul_add, rem_shift, rem_diff;
    logic              rem_ge, neg_q;
    logic [XLEN-1:0]   mul_hi, quot_fix, rem_fix, fix_res;

    assign sgn1_op = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
    assign sgn2_op = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
    assign s1_in   = sgn1_op && op1_i[XLEN-1];
    assign s2_in   = sgn2_op && op2_i[XLEN-1];
    assign op1_mag = s1_in ? -op1_i : op1_i;
    assign op2_mag = s2_in ? -op2_i : op2_i;

    assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q};
    assign mul_add   = prod_q[0] ? mul_sum : {1'b0, prod_q[2*XLEN-1:XLEN]};
    assign rem_shift = (rem_q << 1) | {{XLEN{1'b0}}, prod_q[XLEN-1]};
    assign rem_diff  = rem_shift - {1'b0, mcand_q};
    assign rem_ge    = rem_shift >= {1'b0, mcand_q};

    // High half of the negated 2*XLEN product: ~hi plus the carry out of -lo.
    assign neg_q    = s1_q ^ s2_q;
    assign mul_hi   = neg_q ? (~prod_q[2*XLEN-1:XLEN] + XLEN'(prod_q[XLEN-1:0] == '0))
                            : prod_q[2*XLEN-1:XLEN];
    assign quot_fix = neg_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
    assign rem_fix  = s1_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

    // Result select; a zero divisor bypasses the quotient sign fix.
    always_comb begin
        fix_res = rem_fix;
        unique case (op_q)
            3'd0:              fix_res = prod_q[XLEN-1:0];
            3'd1, 3'd2, 3'd3:  fix_res = mul_hi;
            3'd4, 3'd5:        fix_res = div0_q ? '1 : quot_fix;
            default:           fix_res = rem_fix;
        endcase
    end

    // Next-state and datapath update; flush overrides every state.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        s1_d      = s1_q;
        s2_d      = s2_q;
        div0_d    = div0_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        mcand_d   = mcand_q;
        rem_d     = rem_q;
        rd_d      = rd_q;
        pc_d      = pc_q;
        pc4_d     = pc4_q;
        result_d  = result_q;
        rd_out_d  = rd_out_q;
        pc_out_d  = pc_out_q;
        pc4_out_d = pc4_out_q;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (valid_i) begin
                        op_d    = op_i;
                        s1_d    = s1_in;
                        s2_d    = s2_in;
                        div0_d  = (op2_i == '0);
                        cnt_d   = CNT_W'(XLEN);
                        prod_d  = {{XLEN{1'b0}}, op1_mag};
                        mcand_d = op2_mag;
                        rem_d   = '0;
                        rd_d    = addr_rd_i;
                        pc_d    = pc_i;
                        pc4_d   = pc_plus4_i;
                        state_d = S_BUSY;
                    end
                end
                S_BUSY: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (op_q[2]) begin
                        rem_d  = rem_ge ? rem_diff : rem_shift;
                        prod_d = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-2:0], rem_ge};
                    end else begin
                        prod_d = {mul_add, prod_q[XLEN-1:1]};
                    end
                    if (cnt_q == CNT_W'(1)) state_d = S_FIX;
                end
                S_FIX: begin
                    result_d  = fix_res;
                    rd_out_d  = rd_q;
                    pc_out_d  = pc_q;
                    pc4_out_d = pc4_q;
                    state_d   = S_DONE;
                end
                default: begin
                    if (ready_i) state_d = S_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q      <= '0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            div0_q    <= 1'b0;
            cnt_q     <= '0;
            prod_q    <= '0;
            mcand_q   <= '0;
            rem_q     <= '0;
            rd_q      <= '0;
            pc_q      <= '0;
            pc4_q     <= '0;
            result_q  <= '0;
            rd_out_q  <= '0;
            pc_out_q  <= '0;
            pc4_out_q <= '0;
        end else begin
            op_q      <= op_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            div0_q    <= div0_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            mcand_q   <= mcand_d;
            rem_q     <= rem_d;
            rd_q      <= rd_d;
            pc_q      <= pc_d;
            pc4_q     <= pc4_d;
            result_q  <= result_d;
            rd_out_q  <= rd_out_d;
            pc_out_q  <= pc_out_d;
            pc4_out_q <= pc4_out_d;
        end
    end

    assign ready_o    = (state_q == S_IDLE);
    assign valid_o    = (state_q == S_DONE);
    assign result_o   = result_q;
    assign addr_rd_o  = rd_out_q;
    assign pc_o       = pc_out_q;
    assign pc_plus4_o = pc4_out_q;

endmodule

// File: doc/execute_muldiv.md
# execute_muldiv

Multi-cycle execute-stage unit for the RISC-V M extension, parametrised in operand width. It sits beside the single-cycle ALU path in the execute stage. It accepts one multiply/divide operation per handshake, iterates one bit per cycle, and registers the result together with the pass-through sideband (rd address, pc, pc+4) toward the memory stage. It is the stalling successor of the fixed 32-bit, always-ready execute register: it adds valid/ready flow control, a flush input and XLEN generality.

## Interface
- XLEN, default 32: operand and result width, any even value ≥ 8.
- CNT_W, default $clog2(XLEN)+1: iteration counter width (derived, not overridden).
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous and active-high.
- flush_i  in  1  synchronous abort of any in-flight or held operation.
- valid_i  in  1  an operation is presented.
- ready_o  out  1  the unit can accept an operation; high only in IDLE.
- op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op1_i  in  XLEN  rs1 value.
- op2_i  in  XLEN  rs2 value.
- addr_rd_i  in  5  destination register, passed through.
- pc_i, pc_plus4_i  in  XLEN each  passed through.
- valid_o  out  1  result held and valid.
- ready_i  in  1  downstream accepts the result.
- result_o  out  XLEN  operation result.
- addr_rd_o  out  5  captured rd.
- pc_o, pc_plus4_o  out  XLEN each  captured pc and pc+4.

## Operation
- States: IDLE, BUSY, FIX, DONE. Reset state is IDLE.
- Reset values: every output register is 0, so result_o, addr_rd_o, pc_o, pc_plus4_o and valid_o are all 0. ready_o is 1 because the unit resets to IDLE.
- Accept: valid_i && ready_o && !flush_i at a clock edge.
  - Captures op, sideband and operand magnitudes.
  - Records the operand signs; a sign is taken only for signed operands (MULH: both; MULHSU: op1 only; DIV/REM: both).
  - Loads the counter with XLEN and moves to BUSY.
- BUSY, multiply: shift-add on magnitudes into a 2·XLEN product, one multiplier bit per cycle.
- BUSY, divide: restoring division on magnitudes, one quotient bit per cycle. Partial remainder is XLEN+1 bits.
- The counter decrements each BUSY cycle. The counter reaching 0 moves the unit to FIX.
- FIX applies the sign correction and selects the result, then moves to DONE:
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits of the product. The product is negated first when the result sign is negative.
  - Quotient sign is s1^s2. Remainder takes the sign of the dividend.
- Divide by zero (op2 == 0):
  - DIV/DIVU return all ones, with no sign fix.
  - REM/REMU return op1 unchanged.
- Signed overflow (DIV of −2^(XLEN−1) by −1): returns the dividend. REM returns 0. The magnitude algorithm yields this naturally; the bench checks it explicitly.
- DONE: valid_o = 1 and the outputs are held stable until ready_i. valid_o && ready_i returns the unit to IDLE with valid_o = 0.
- flush_i in any state moves to IDLE with valid_o = 0 on the next edge. The data outputs keep their last values.
- flush_i together with valid_i in IDLE: no accept.
- An asynchronous rst_i mid-operation forces IDLE and the zero output values immediately. There is no partial-result leakage.

## Timing
- Accept at edge E0.
- BUSY occupies edges E1..E(XLEN).
- FIX happens at edge E(XLEN+1). valid_o rises after E(XLEN+1), giving a latency of XLEN+1 cycles: 33 for XLEN = 32.
- ready_o returns high in the cycle after the DONE handshake edge. The minimum issue interval is XLEN+3 cycles.
- With ready_i held low, DONE persists indefinitely with all outputs stable.
- ready_o is a registered-state decode with no combinational path from valid_i or ready_i. valid_o is a registered-state decode.

## Test plan
- Reset mid-BUSY: assert rst_i 10 cycles after accepting MUL 7×6 → outputs immediately 0, ready_o = 1. A new MUL 7×6 gives result 42 after 33 cycles.
- MULH −1×−1 (0xFFFFFFFF each) → 0. MULHU with the same operands → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF. MUL 0x80000000×2 → 0.
- DIV −7/2 → 0xFFFFFFFD (−3). REM −7/2 → 0xFFFFFFFF (−1). DIVU 100/7 → 14. REMU 100/7 → 2.
- Boundaries:
  - DIV 5/0 → 0xFFFFFFFF. REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM with the same operands → 0.
- Backpressure: ready_i low 20 cycles after valid_o rises → result and sideband (rd = 13, pc = 0x100) stable. ready_o = 0 until one cycle after the ready_i handshake.
- Flush: flush_i in BUSY, in DONE, and coincident with valid_i in IDLE → IDLE next edge, valid_o = 0, no accept. Repeat the arithmetic checks with XLEN = 16 and 64.
